// File: rtl/fixed_point_mul_pkg.sv
// Shared helpers for the fixed-point multiplier: product width and
// saturation limits for a signed two's-complement word of a given width.
package fixed_point_mul_pkg;

    function automatic int prod_width(input int i1, input int f1,
                                      input int i2, input int f2);
        return i1 + i2 + f1 + f2;
    endfunction

    // Limits are returned 64 bits wide; callers size-cast to their own width.
    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/fixed_point_saturate.sv
// Combinational fraction realignment, range check and clamp from one signed
// Q-format to another, with positive/negative saturation flags.
module fixed_point_saturate
    import fixed_point_mul_pkg::*;
#(
    parameter int IN_W  = 11,
    parameter int IN_F  = 4,
    parameter int OUT_W = 8,
    parameter int OUT_F = 3
) (
    input  logic signed [IN_W-1:0]  value,
    output logic        [OUT_W-1:0] result,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int D  = IN_F - OUT_F;
    // Working width holds the fully shifted value plus a spare sign bit, so the
    // range comparison is exact whether the output is wider or narrower.
    localparam int LW = IN_W + ((D < 0) ? -D : 0);
    localparam int AW = ((LW > OUT_W) ? LW : OUT_W) + 1;

    localparam logic signed [AW-1:0] MAX_V = AW'(sat_max(OUT_W));
    localparam logic signed [AW-1:0] MIN_V = AW'(sat_min(OUT_W));

    logic signed [AW-1:0] ext;
    logic signed [AW-1:0] aligned;

    assign ext = AW'(value);

    generate
        if (D > 0) begin : g_shr
            assign aligned = ext >>> D;
        end else if (D < 0) begin : g_shl
            assign aligned = ext <<< (-D);
        end else begin : g_keep
            assign aligned = ext;
        end
    endgenerate

    always_comb begin
        result    = aligned[OUT_W-1:0];
        overflow  = 1'b0;
        underflow = 1'b0;
        if (aligned > MAX_V) begin
            result   = MAX_V[OUT_W-1:0];
            overflow = 1'b1;
        end else if (aligned < MIN_V) begin
            result    = MIN_V[OUT_W-1:0];
            underflow = 1'b1;
        end
    end

endmodule

// File: rtl/fixed_point_mul.sv
// Registered signed fixed-point multiplier: exact product, realigned and
// saturated to the output Q-format, one cycle of latency.
module fixed_point_mul
    import fixed_point_mul_pkg::*;
#(
    parameter int I1    = 3,
    parameter int F1    = 2,
    parameter int I2    = 4,
    parameter int F2    = 2,
    parameter int OUT_I = 5,
    parameter int OUT_F = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [I1+F1-1:0]   a,
    input  logic signed [I2+F2-1:0]   b,
    output logic [OUT_I+OUT_F-1:0]    out,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int PW    = prod_width(I1, F1, I2, F2);
    localparam int OUT_W = OUT_I + OUT_F;

    logic signed [PW-1:0]    product;
    logic        [OUT_W-1:0] sat_result;
    logic                    sat_overflow;
    logic                    sat_underflow;

    // Both operands are sign-extended to the product width, which always holds
    // the exact result.
    assign product = PW'(a) * PW'(b);

    fixed_point_saturate #(
        .IN_W  (PW),
        .IN_F  (F1 + F2),
        .OUT_W (OUT_W),
        .OUT_F (OUT_F)
    ) u_saturate (
        .value     (product),
        .result    (sat_result),
        .overflow  (sat_overflow),
        .underflow (sat_underflow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            out       <= sat_result;
            overflow  <= sat_overflow;
            underflow <= sat_underflow;
        end
    end

endmodule

// File: tb/tb_fixed_point_mul.sv
// Self-checking bench for fixed_point_mul: directed corner cases plus random
// operands against a real-valued floor/clamp reference model.
module tb_fixed_point_mul;

    localparam int I1 = 3, F1 = 2, I2 = 4, F2 = 2, OUT_I = 5, OUT_F = 3;
    localparam int A_W = I1 + F1;
    localparam int B_W = I2 + F2;
    localparam int O_W = OUT_I + OUT_F;

    logic           clk = 1'b0;
    logic           rst;
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic [O_W-1:0] out;
    logic           overflow;
    logic           underflow;

    int checks   = 0;
    int failures = 0;
    logic [O_W+1:0] exp_q[$];

    fixed_point_mul #(
        .I1(I1), .F1(F1), .I2(I2), .F2(F2), .OUT_I(OUT_I), .OUT_F(OUT_F)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .out       (out),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: real product value, floor to the output LSB, clamp to range.
    function automatic logic [O_W+1:0] model(input int ra, input int rb);
        int sa, sb, p, scale, q, maxv, minv;
        logic ov, un;
        logic [O_W-1:0] o;
        sa = (ra >= (1 << (A_W - 1))) ? ra - (1 << A_W) : ra;
        sb = (rb >= (1 << (B_W - 1))) ? rb - (1 << B_W) : rb;
        p  = sa * sb;
        if (F1 + F2 >= OUT_F) begin
            scale = 1 << (F1 + F2 - OUT_F);
            q = p / scale;
            if (p < 0 && (p % scale) != 0) q = q - 1;
        end else begin
            q = p * (1 << (OUT_F - F1 - F2));
        end
        maxv = (1 << (O_W - 1)) - 1;
        minv = -(1 << (O_W - 1));
        ov = 1'b0;
        un = 1'b0;
        if (q > maxv) begin
            q  = maxv;
            ov = 1'b1;
        end else if (q < minv) begin
            q  = minv;
            un = 1'b1;
        end
        o = q[O_W-1:0];
        return {ov, un, o};
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_out"}, 32'(out), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
        check({tag, "_unf"}, 32'(underflow), 32'd0);
    endtask

    // Drive one sample between edges, check its result just after the edge,
    // then scramble inputs mid-cycle and confirm the output holds.
    task automatic drive(input int ra, input int rb, input string tag);
        logic [O_W+1:0] e;
        @(negedge clk);
        a = ra[A_W-1:0];
        b = rb[B_W-1:0];
        exp_q.push_back(model(ra, rb));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, "_out"}, 32'(out), 32'(e[O_W-1:0]));
        check({tag, "_ovf"}, 32'(overflow), 32'(e[O_W+1]));
        check({tag, "_unf"}, 32'(underflow), 32'(e[O_W]));
        check({tag, "_excl"}, 32'(overflow & underflow), 32'd0);
        a = A_W'($urandom);
        b = B_W'($urandom);
        #2;
        check({tag, "_hold"}, 32'(out), 32'(e[O_W-1:0]));
    endtask

    initial begin
        rst = 1'b1;
        a   = 5'b01111;
        b   = 6'b011111;
        #1;
        check_idle("rst_async");
        repeat (2) @(posedge clk);
        #1;
        check_idle("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle("rst_release");

        drive(5'b00100, 6'b000010, "pos_half");
        drive(5'b01111, 6'b011111, "ovf_max");
        drive(5'b00100, 6'b000010, "ovf_clear");
        drive(5'b10000, 6'b100000, "ovf_negneg");
        drive(5'b10000, 6'b011111, "unf");
        drive(5'b10000, 6'b010000, "min_exact");
        drive(5'b00001, 6'b000001, "trunc_pos");
        drive(5'b11111, 6'b000001, "trunc_neg");
        drive(5'b01011, 6'b110100, "mixed");
        drive(5'b00000, 6'b100000, "zero");

        // Exact explicit values for the plan vectors, independent of the model.
        @(negedge clk);
        a = 5'b01011;
        b = 6'b110100;
        @(posedge clk);
        #1;
        check("mixed_const", 32'(out), 32'h0000_00BE);
        @(negedge clk);
        a = 5'b01111;
        b = 6'b011111;
        @(posedge clk);
        #1;
        check("sat_const", 32'(out), 32'h0000_007F);
        check("sat_const_ovf", 32'(overflow), 32'd1);

        // Reset mid-cycle while an overflow result is held.
        #2;
        rst = 1'b1;
        #1;
        check_idle("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle("rst_mid_release");

        for (int i = 0; i < 300; i++) begin
            drive(int'($urandom_range(0, (1 << A_W) - 1)),
                  int'($urandom_range(0, (1 << B_W) - 1)), "rand");
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fixed_point_mul.md
Name:
fixed_point_mul

Overview:
- Registered signed fixed-point multiplier: multiplies a Q(I1.F1) operand by a Q(I2.F2) operand.
- Realigns the full-precision product to a Q(OUT_I.OUT_F) result, saturating on range overflow.
- Flags positive saturation (overflow) and negative saturation (underflow).
- Used as a datapath arithmetic leaf; one-cycle latency, no handshake.

Parameters:
- I1, 3, integer bits of operand a (sign bit included).
- F1, 2, fraction bits of operand a.
- I2, 4, integer bits of operand b (sign bit included).
- F2, 2, fraction bits of operand b.
- OUT_I, 5, integer bits of result (sign bit included).
- OUT_F, 3, fraction bits of result.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- a  input  I1+F1  signed two's-complement operand, value = raw/2^F1.
- b  input  I2+F2  signed two's-complement operand, value = raw/2^F2.
- out  output  OUT_I+OUT_F  registered signed result, value = raw/2^OUT_F.
- overflow  output  1  registered; result saturated at positive maximum.
- underflow  output  1  registered; result saturated at negative minimum.

Behaviour:
- Reset: while rst=1, out=0, overflow=0 and underflow=0, asynchronously, regardless of clk.
- Latency: a and b are sampled at rising edge N; out and flags are valid after edge N and hold until the next edge. There is no input register stage.
- Full product: signed, I1+I2+F1+F2 bits wide, with F1+F2 fraction bits. It is exact and never overflows internally.
- Fraction alignment, with D = (F1+F2) - OUT_F:
  - D>0: arithmetic shift right by D (truncation toward negative infinity, no rounding).
  - D<0: shift left by -D, zero-filled.
  - D=0: unchanged.
- Range check on the aligned value against [-2^(OUT_I+OUT_F-1), 2^(OUT_I+OUT_F-1)-1]:
  - Above range: out = max positive (0111..1), overflow=1, underflow=0.
  - Below range: out = min negative (1000..0), underflow=1, overflow=0.
  - In range: out = aligned value truncated to the output width, both flags 0.
- overflow and underflow are never both 1.
- Flags are per-sample, not sticky; they clear on the next in-range product.
- Exact boundary values (max or min) are in range and do not set a flag.
- The width check must be generic for any OUT_I wider or narrower than I1+I2. When the output is wide enough, saturation logic is inert.
- Inputs changing mid-cycle have no effect until the next edge.
- Reset asserted mid-operation clears outputs immediately. The first result after rst release appears after the first rising edge.

Decomposition:
- Shared package: function computing product width (I1+I2+F1+F2) and the saturation constants (max positive and min negative for a given width).
- One natural sub-module: fixed_point_saturate (combinational align + range check + clamp, parameterised on input Q-format and output Q-format).
- Top-level fixed_point_mul holds the multiply and the output register.

Test Plan:
- Reset: assert rst with a=5'b01111, b=6'b011111 -> out=8'h00, overflow=0, underflow=0 immediately and throughout reset.
- In-range positive: a=5'b00100 (1.0), b=6'b000010 (0.5) -> after one edge out=8'h04 (0.5), flags 0.
- Positive saturation: a=5'b01111 (3.75), b=6'b011111 (7.75) = 29.0625 -> out=8'h7F, overflow=1, underflow=0. Also a=5'b10000, b=6'b100000 (+32) -> out=8'h7F, overflow=1.
- Negative saturation and boundary:
  - a=5'b10000 (-4), b=6'b011111 (7.75) = -31 -> out=8'h80, underflow=1.
  - a=5'b10000, b=6'b010000 (4.0) = -16 exactly -> out=8'h80, underflow=0.
- Truncation: a=5'b00001, b=6'b000001 (+0.0625) -> out=8'h00. a=5'b11111, b=6'b000001 (-0.0625) -> out=8'hFF (-0.125, floor).
- Mixed-sign in range: a=5'b01011 (2.75), b=6'b110100 (-3.0) -> out=8'hBE (-8.25), flags 0. A following in-range sample after an overflow clears overflow to 0.
